// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment scanner with hex/message modes and a reveal wipe.
// Optional leading-zero blanking in hex mode is built when SEG7_LZ_BLANK_EN is defined.
module seg7_scan_driver #(
   parameter int unsigned DIGITS   = 8,
   parameter int unsigned SCAN_DIV = 100000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*DIGITS-1:0]   data,
   input  logic [DIGITS-1:0]     dp_mask,
   input  logic                  msg_en,
   input  logic [8*DIGITS-1:0]   msg,
   output logic [DIGITS-1:0]     an,
   output logic [7:0]            seg,
   output logic                  frame
);

   localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned IW = $clog2(DIGITS + 1);
   localparam logic [PW-1:0] PreLast = PW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IdxLast = IW'(DIGITS - 1);
   localparam logic [IW-1:0] CntFull = IW'(DIGITS);

   logic [PW-1:0]     presc_q;
   logic [IW-1:0]     idx_q;
   logic [IW-1:0]     cnt_q;
   logic              upd_q;
   logic              frame_q;
   logic              hist_q;
   logic [DIGITS-1:0] an_q;
   logic [7:0]        seg_q;

   logic              tick;
   logic              wrap;
   logic [DIGITS-1:0] an_d;
   logic [7:0]        seg_d;
   logic [3:0]        cur_nib;
   logic [7:0]        cur_msg;
   logic              cur_dp;
   logic              cur_lz;
   logic [7:0]        hex_pat;

   function automatic logic [7:0] hex_decode(input logic [3:0] nib);
      logic [7:0] p;
      unique case (nib)
         4'h0: p = 8'h03;
         4'h1: p = 8'h9F;
         4'h2: p = 8'h25;
         4'h3: p = 8'h0D;
         4'h4: p = 8'h99;
         4'h5: p = 8'h49;
         4'h6: p = 8'h41;
         4'h7: p = 8'h1F;
         4'h8: p = 8'h01;
         4'h9: p = 8'h09;
         4'hA: p = 8'h11;
         4'hB: p = 8'hC1;
         4'hC: p = 8'h63;
         4'hD: p = 8'h85;
         4'hE: p = 8'h61;
         default: p = 8'h71;
      endcase
      return p;
   endfunction

   assign tick = (presc_q == PreLast);
   assign wrap = (idx_q == IdxLast);

`ifdef SEG7_LZ_BLANK_EN
   logic [DIGITS-1:0] lz;

   // lz[i] is set while every nibble from the top digit down to i is zero.
   always_comb begin
      logic zero_run;
      zero_run = 1'b1;
      lz       = '0;
      for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
         zero_run = zero_run & (data[4*i +: 4] == 4'h0);
         lz[i]    = zero_run;
      end
   end
`endif

   always_comb begin
      cur_nib = '0;
      cur_msg = 8'hFF;
      cur_dp  = 1'b0;
      cur_lz  = 1'b0;
      an_d    = '1;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (idx_q == IW'(i)) begin
            cur_nib = data[4*i +: 4];
            cur_msg = msg[8*i +: 8];
            cur_dp  = dp_mask[i];
`ifdef SEG7_LZ_BLANK_EN
            cur_lz  = lz[i];
`endif
            an_d[i] = 1'b0;
         end
      end

      hex_pat = hex_decode(cur_nib);
      if (cur_dp) begin
         hex_pat[0] = 1'b0;
      end

      if (msg_en) begin
         seg_d = cur_msg;
      end else if (cur_lz) begin
         seg_d = 8'hFF;
      end else begin
         seg_d = hex_pat;
      end

      // Wipe blanking; cnt_q never drops below 1, so digit 0 always shows.
      if ((idx_q != '0) && (idx_q >= cnt_q)) begin
         seg_d = 8'hFF;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q <= '0;
         idx_q   <= '0;
         upd_q   <= 1'b0;
         frame_q <= 1'b0;
         an_q    <= '1;
         seg_q   <= 8'hFF;
         cnt_q   <= CntFull;
         hist_q  <= msg_en;
      end else begin
         presc_q <= tick ? '0 : presc_q + 1'b1;
         upd_q   <= tick;
         frame_q <= tick & wrap;
         if (tick) begin
            idx_q <= wrap ? '0 : idx_q + 1'b1;
         end
         // an/seg follow the index one cycle after it moves.
         if (upd_q) begin
            an_q  <= an_d;
            seg_q <= seg_d;
         end
         hist_q <= msg_en;
         if (msg_en != hist_q) begin
            cnt_q <= IW'(1);
         end else if (frame_q && (cnt_q != CntFull)) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign an    = an_q;
   assign seg   = seg_q;
   assign frame = frame_q;

endmodule
